// File: rtl/roboant_world.sv
// roboant_world: grid/wall environment model that closes the loop around the RoboAnt controller
module roboant_world #(
    parameter int WIDTH = 8,
    parameter int HEIGHT = 8,
    parameter logic [WIDTH*HEIGHT-1:0] WALLS = '0,
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter logic [1:0] START_DIR = 2'd0,
    parameter int GOAL_X = WIDTH - 1,
    parameter int GOAL_Y = HEIGHT - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      TL,
    input  logic                      TR,
    input  logic                      F,
    output logic                      L,
    output logic                      R,
    output logic [$clog2(WIDTH)-1:0]  pos_x,
    output logic [$clog2(HEIGHT)-1:0] pos_y,
    output logic [1:0]                heading,
    output logic [15:0]               steps,
    output logic                      bump,
    output logic                      at_goal
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    function automatic int dx(input logic [1:0] d);
        return d == 2'd1 ? 1 : d == 2'd3 ? -1 : 0;
    endfunction

    function automatic int dy(input logic [1:0] d);
        return d == 2'd0 ? 1 : d == 2'd2 ? -1 : 0;
    endfunction

    // Off-grid cells are walls, so the ant can never leave the map.
    function automatic logic wall(input int x, input int y);
        logic [WIDTH*HEIGHT-1:0] m;
        if (x < 0 || x >= WIDTH || y < 0 || y >= HEIGHT) return 1'b1;
        m = WALLS >> (y * WIDTH + x);
        return m[0];
    endfunction

    // Antenna contacts {L, R} for an ant at (x, y) facing h.
    function automatic logic [1:0] sense(input int x, input int y, input logic [1:0] h);
        logic [1:0] hl;
        logic [1:0] hr;
        int ax;
        int ay;
        logic wa;
        hl = h - 2'd1;
        hr = h + 2'd1;
        ax = x + dx(h);
        ay = y + dy(h);
        wa = wall(ax, ay);
        return {wa | wall(ax + dx(hl), ay + dy(hl)), wa | wall(ax + dx(hr), ay + dy(hr))};
    endfunction

    logic       f, tl, tr, blocked, hit_goal;
    int         ax, ay, nx, ny;
    logic [1:0] nh, ns;

    // Decode commands against the current state and derive next position, heading and sensors.
    always_comb begin
        f = F === 1'b1;
        tl = TL === 1'b1;
        tr = TR === 1'b1;
        ax = int'(pos_x) + dx(heading);
        ay = int'(pos_y) + dy(heading);
        blocked = f && wall(ax, ay);
        nx = f && !blocked ? ax : int'(pos_x);
        ny = f && !blocked ? ay : int'(pos_y);
        nh = f ? heading : tl && !tr ? heading - 2'd1 : tr && !tl ? heading + 2'd1 : heading;
        ns = sense(nx, ny, nh);
        hit_goal = (nx == GOAL_X && ny == GOAL_Y) || (int'(pos_x) == GOAL_X && int'(pos_y) == GOAL_Y);
    end

    // World state and registered sensors; sensors track the next-state pose so they match pos/heading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x   <= XW'(START_X);
            pos_y   <= YW'(START_Y);
            heading <= START_DIR;
            steps   <= '0;
            bump    <= 1'b0;
            at_goal <= 1'b0;
            L       <= 1'b0;
            R       <= 1'b0;
        end else begin
            pos_x   <= XW'(nx);
            pos_y   <= YW'(ny);
            heading <= nh;
            steps   <= steps + 16'(f && !blocked && steps != 16'hFFFF);
            bump    <= blocked;
            at_goal <= at_goal | hit_goal;
            L       <= ns[1];
            R       <= ns[0];
        end
    end
endmodule

// File: doc/roboant_world.md
Name: roboant_world

Overview:
- Behavioural-synthesizable environment model for the RoboAnt controller: the other end of its sensor/actuator interface.
- Consumes the controller's TL/TR/F commands, tracks the ant's grid position and heading over a wall map, and produces the L/R antenna contacts the controller reads.
- Closes the loop so controller plus world run autonomously in simulation or on FPGA.
- Also reports step count, bump events and goal arrival for scoreboarding.

Parameters:
- WIDTH, 8, grid columns (2..256)
- HEIGHT, 8, grid rows (2..256)
- WALLS, all zeros, WIDTH*HEIGHT-bit map; bit y*WIDTH+x set = wall cell
- START_X, 0, reset x coordinate (cell must not be a wall)
- START_Y, 0, reset y coordinate
- START_DIR, 0, reset heading (0=N, 1=E, 2=S, 3=W)
- GOAL_X, WIDTH-1, goal x coordinate
- GOAL_Y, HEIGHT-1, goal y coordinate

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- TL  in  1  turn-left command from controller
- TR  in  1  turn-right command from controller
- F  in  1  forward command from controller
- L  out  1  left antenna contact, registered
- R  out  1  right antenna contact, registered
- pos_x  out  $clog2(WIDTH)  current x
- pos_y  out  $clog2(HEIGHT)  current y
- heading  out  2  current heading
- steps  out  16  successful forward moves, saturating
- bump  out  1  one-cycle pulse: F issued into a blocked cell
- at_goal  out  1  sticky: goal cell reached since reset

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values while rst=1, taking effect immediately (async):
  - pos = (START_X, START_Y), heading = START_DIR
  - L=0, R=0, steps=0, bump=0, at_goal=0
- Coordinates: N = y+1, E = x+1, S = y-1, W = x-1.
- Any cell outside 0..WIDTH-1 / 0..HEIGHT-1 counts as a wall.
- Cell classification, relative to the current position and heading:
  - ahead: one step in heading
  - front-left: ahead plus one step toward heading-1
  - front-right: ahead plus one step toward heading+1
- Command decode each rising edge, evaluated on current state:
  - F=1: if ahead is open, move to ahead, steps += 1 (saturating at 65535). If ahead is a wall, position is unchanged and bump=1 for that cycle. TL/TR are ignored while F=1 (F has priority).
  - F=0, TL=1, TR=0: heading = heading-1 mod 4.
  - F=0, TR=1, TL=0: heading = heading+1 mod 4.
  - F=0, TL=1, TR=1: no change.
  - All zero: hold.
  - X/Z on any command input is treated as 0.
- Sensors, registered at the same edge from the next-state position and heading:
  - L = wall(ahead) OR wall(front-left)
  - R = wall(ahead) OR wall(front-right)
  - L/R therefore always describe the state shown on pos/heading.
  - Exception: the reset cycle, where both read 0 until the first edge after rst deasserts.
- Latency: a command sampled at edge n is visible on pos/heading/L/R/bump immediately after edge n. Command to sensor response is 1 cycle.
- at_goal: set at the edge where the next position equals (GOAL_X, GOAL_Y). It is also set at the first edge after reset if start equals goal. Once set it stays 1 until reset.
- bump is 0 on every cycle without a blocked F.
- Heading wrap: W+TR→N and N+TL→W.
- Position never leaves the grid and never enters a wall cell.
- Reset mid-motion: all state returns asynchronously to its reset value with no partial update. The first edge after deassertion evaluates commands normally.

Test Plan:
- Defaults (8x8, no walls, start (0,0) N), rst high, then low, one edge with no command → pos=(0,0), heading=0, steps=0, L=1 (front-left off-grid), R=0, bump=0.
- F held 7 cycles → pos_y 1..7 one per edge, steps=7, final L=1 R=1. 8th F cycle → bump=1 for exactly one cycle, pos_y stays 7, steps stays 7.
- From (0,0) N: TR → heading=1, L=0, R=1 (front-right (1,-1) off-grid). TR ×3 more → heading 2, 3, 0 (wrap). TL → heading=3.
- GOAL=(3,0): TR then F×3 → pos=(3,0), at_goal=1 after the 3rd F edge. F×2 more → at_goal stays 1, steps=5.
- WALLS bit (0,2) set: F → pos (0,1), L=1 R=1 (ahead walled). F again → bump=1, steps=1. F=1 with TL=1 → position/heading unchanged, bump=1. TL=1 with TR=1 → no change.
- Mid-sequence async rst pulse between edges (after 4 moves) → pos/heading/steps/at_goal/L/R return to reset values before the next edge. Next F → pos_y=1, steps=1.
